bcd_stopwatch_ctrl: RTL

Controller that sequences a chain of cascaded BCD decade digits as a start/stop/lap stopwatch. Accepts single-cycle command pulses and a timebase `tick`, runs a four-state FSM, advances the digit chain with proper decade carry, and provides a freezable display value for the seven-segment front end. Sits between the timebase divider and the display driver in the sequential-circuits family.

---
 rtl/bcd_stopwatch_ctrl_pkg.sv | 18 +
 rtl/bcd_stopwatch_ctrl_if.sv | 28 ++
 rtl/bcd_stopwatch_ctrl_digit.sv | 28 ++
 rtl/bcd_stopwatch_ctrl.sv | 94 +++++++++
 4 files changed

// File: rtl/bcd_stopwatch_ctrl_pkg.sv
// Shared types and constants for the BCD stopwatch controller and its digit cells.
package bcd_pkg;

    localparam int          BCD_W   = 4;
    localparam logic [3:0]  BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        LAP   = 2'd3
    } state_t;

    function automatic logic is_running(input state_t s);
        return (s == RUN) || (s == LAP);
    endfunction

endpackage

// File: rtl/bcd_stopwatch_ctrl_if.sv
// Command and status bundle between the stopwatch controller and its host/display side.
interface bcd_stopwatch_ctrl_if #(
    parameter int DIGITS = 4
) ();

    logic                   tick;
    logic                   start;
    logic                   stop;
    logic                   clear;
    logic                   lap;
    logic [4*DIGITS-1:0]    count;
    logic [4*DIGITS-1:0]    display;
    logic [1:0]             state;
    logic                   running;
    logic                   carry_out;
    logic                   overflow;

    modport master (
        output tick, start, stop, clear, lap,
        input  count, display, state, running, carry_out, overflow
    );

    modport slave (
        input  tick, start, stop, clear, lap,
        output count, display, state, running, carry_out, overflow
    );

endinterface

// File: rtl/bcd_stopwatch_ctrl_digit.sv
// One synchronous decade (0..9) counter cell; at_max flags 9 so the chain can ripple enables.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [BCD_W-1:0] q,
    output logic             at_max
);

    logic [BCD_W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (en) begin
            r_q <= (r_q == BCD_MAX) ? '0 : r_q + 4'd1;
        end
    end

    assign q      = r_q;
    assign at_max = (r_q == BCD_MAX);

endmodule

// File: rtl/bcd_stopwatch_ctrl.sv
// Start/stop/lap stopwatch sequencer driving a cascaded BCD digit chain with a freezable display.
module bcd_stopwatch_ctrl
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    bcd_stopwatch_ctrl_if.slave  sw
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_lap_load;
    logic                w_tick_taken;
    logic                w_wrap;
    logic [DIGITS-1:0]   w_at_max;
    logic [DIGITS-1:0]   w_en;
    logic [4*DIGITS-1:0] w_count;
    logic [4*DIGITS-1:0] r_lap;
    logic                r_carry;
    logic                r_overflow;

    // Only the highest-priority asserted command acts, even if it is ignored in this state.
    always_comb begin
        w_state_nxt = r_state;
        w_lap_load  = 1'b0;
        if (sw.clear) begin
            w_state_nxt = IDLE;
        end else if (sw.stop) begin
            if (is_running(r_state)) w_state_nxt = PAUSE;
        end else if (sw.start) begin
            if ((r_state == IDLE) || (r_state == PAUSE)) w_state_nxt = RUN;
        end else if (sw.lap) begin
            if (r_state == RUN) begin
                w_state_nxt = LAP;
                w_lap_load  = 1'b1;
            end else if (r_state == LAP) begin
                w_state_nxt = RUN;
            end
        end
    end

    assign w_tick_taken = sw.tick && is_running(r_state);

    always_comb begin
        w_en    = '0;
        w_en[0] = w_tick_taken;
        for (int unsigned i = 1; i < DIGITS; i++) begin
            w_en[i] = w_en[i-1] & w_at_max[i-1];
        end
    end

    assign w_wrap = w_en[DIGITS-1] & w_at_max[DIGITS-1];

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .clk    (clk),
            .reset  (reset),
            .clr    (sw.clear),
            .en     (w_en[g]),
            .q      (w_count[g*BCD_W +: BCD_W]),
            .at_max (w_at_max[g])
        );
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_lap      <= '0;
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (sw.clear) begin
                r_lap      <= '0;
                r_carry    <= 1'b0;
                r_overflow <= 1'b0;
            end else begin
                if (w_lap_load) r_lap <= w_count;
                r_carry <= w_wrap;
                if (w_wrap) r_overflow <= 1'b1;
            end
        end
    end

    assign sw.count     = w_count;
    assign sw.display   = (r_state == LAP) ? r_lap : w_count;
    assign sw.state     = r_state;
    assign sw.running   = is_running(r_state);
    assign sw.carry_out = r_carry;
    assign sw.overflow  = r_overflow;

endmodule
